// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: ID/EX/MEM hazard inputs and stall/flush/freeze controls of the pipeline
interface hazard_stall_unit_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_Branch;
  logic        ID_Jump;
  logic        ID_BranchTaken;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [4:0]  EX_Rt;
  logic [4:0]  EX_Rd;
  logic        MEM_MemRead;
  logic [4:0]  MEM_Rd;
  logic        Mem_Busy;
  logic        PCWrite;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Bubble;
  logic        Freeze;
  logic        Mem_Timeout;
  logic [15:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Jump, ID_BranchTaken,
    output EX_MemRead, EX_RegWrite, EX_Rt, EX_Rd, MEM_MemRead, MEM_Rd, Mem_Busy,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Freeze, Mem_Timeout, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_Jump, ID_BranchTaken,
    input  EX_MemRead, EX_RegWrite, EX_Rt, EX_Rd, MEM_MemRead, MEM_Rd, Mem_Busy,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Freeze, Mem_Timeout, StallCount
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use/branch stall, flush and memory-freeze control; `HAZARD_STALL_STATS_EN enables the StallCount bubble counter
module hazard_stall_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                reset_n,
  hazard_stall_unit_if.slave bus
);
  typedef enum logic {RUN, STALL2} state_t;

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t     r_state, w_next;
  logic [7:0] r_busy_cnt, w_busy_next;
  logic       r_timeout;
  logic       w_lu, w_be, w_bm, w_bl, w_stall, w_bubble;

  assign w_lu = bus.EX_MemRead && bus.EX_Rt != 5'd0 &&
                (bus.EX_Rt == bus.ID_Rs || (bus.ID_UsesRt && bus.EX_Rt == bus.ID_Rt));
  assign w_be = bus.ID_Branch && bus.EX_RegWrite && bus.EX_Rd != 5'd0 &&
                (bus.EX_Rd == bus.ID_Rs || bus.EX_Rd == bus.ID_Rt);
  assign w_bm = bus.ID_Branch && bus.MEM_MemRead && bus.MEM_Rd != 5'd0 &&
                (bus.MEM_Rd == bus.ID_Rs || bus.MEM_Rd == bus.ID_Rt);
  assign w_bl = bus.ID_Branch && w_lu;
  assign w_stall = r_state == STALL2 || w_lu || w_be || w_bm;
  assign w_busy_next = !bus.Mem_Busy ? 8'd0 : (r_busy_cnt == 8'hFF) ? 8'hFF : r_busy_cnt + 8'd1;

  // next state: a freeze holds, STALL2 always returns to RUN, a load feeding a branch needs a second bubble
  always_comb w_next = bus.Mem_Busy ? r_state : (r_state == STALL2) ? RUN : w_bl ? STALL2 : RUN;

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= RUN;
    else r_state <= w_next;

  // consecutive busy-cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_busy_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_busy_cnt <= w_busy_next;
      r_timeout  <= r_timeout | (bus.Mem_Busy && w_busy_next == TIMEOUT);
    end

  // control outputs: reset forcing first, then freeze, then stall, then flush on taken branch/jump
  always_comb begin
    w_bubble        = !reset_n || (!bus.Mem_Busy && w_stall);
    bus.Freeze      = reset_n && bus.Mem_Busy;
    bus.PCWrite     = reset_n && !bus.Mem_Busy && !w_stall;
    bus.IFID_Write  = reset_n && !bus.Mem_Busy && !w_stall;
    bus.IDEX_Bubble = w_bubble;
    bus.IFID_Flush  = !reset_n || (!bus.Mem_Busy && !w_stall &&
                      (bus.ID_Jump || (bus.ID_Branch && bus.ID_BranchTaken)));
    bus.Mem_Timeout = r_timeout;
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] r_stall_cnt;

  // saturating count of bubble cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_stall_cnt <= 16'd0;
    else if (w_bubble && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;

  assign bus.StallCount = r_stall_cnt;
`else
  assign bus.StallCount = 16'd0;
`endif
endmodule
